digit_inc_arbiter: RTL and testbench

DIGIT_INC_ARBITER -- requirements
Module: digit_inc_arbiter

---
 rtl/digit_inc_arbiter.sv | 97 +++++++++
 tb/tb_digit_inc_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_inc_arbiter.sv
// Four hex digits, each bumped up or down by a rising edge on its own switch.
// Pending requests are served round-robin through a single shared 4-bit adder.
module digit_inc_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw,
    input  logic        dir,
    output logic [15:0] num,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [3:0]  pend
);
    typedef enum logic [1:0] {S_IDLE, S_OPER, S_WB} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_s1, r_s2, r_s3;
    logic [3:0]  r_pend;
    logic [1:0]  r_ptr, r_idx;
    logic [3:0]  r_opnd;
    logic        r_dir;
    logic [15:0] r_num;

    logic [3:0]  w_rise, w_grant, w_pend_nxt, w_digit, w_sum;
    logic [1:0]  w_pick;
    logic        w_start;

    assign w_rise     = r_s2 & ~r_s3;
    assign w_grant    = (r_state == S_OPER) ? (4'b0001 << r_idx) : 4'b0000;
    // Leaving OPER is unconditional, so the grant is also the clear; a new rise wins.
    assign w_pend_nxt = (r_pend & ~w_grant) | w_rise;

    always_comb begin
        w_pick = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            logic [1:0] c;
            c = r_ptr + 2'(k);
            if (r_pend[c]) w_pick = c;
        end
    end

    assign w_digit = r_num[{w_pick, 2'b00} +: 4];
    assign w_sum   = r_opnd + (r_dir ? 4'hF : 4'h1);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: if (|r_pend) begin
                w_state_nxt = S_OPER;
                w_start     = 1'b1;
            end
            S_OPER: w_state_nxt = S_WB;
            S_WB: begin
                if (|r_pend) begin
                    w_state_nxt = S_OPER;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_pend  <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_opnd  <= '0;
            r_dir   <= 1'b0;
            r_num   <= 16'h0010;
        end else begin
            r_s1    <= sw;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pend  <= w_pend_nxt;
            r_state <= w_state_nxt;
            if (w_start) begin
                r_idx  <= w_pick;
                r_opnd <= w_digit;
                r_dir  <= dir;
                r_ptr  <= w_pick + 2'd1;
            end
            if (r_state == S_OPER) r_num[{r_idx, 2'b00} +: 4] <= w_sum;
        end
    end

    assign num   = r_num;
    assign grant = w_grant;
    assign busy  = (r_state != S_IDLE);
    assign pend  = r_pend;
endmodule

// File: tb/tb_digit_inc_arbiter.sv
// Scoreboard bench: a cycle-timed behavioural model predicts grants and digit
// values from switch edges; a monitor compares the DUT against it every cycle.
module tb_digit_inc_arbiter;
    logic        clk, rst, dir;
    logic [3:0]  sw;
    logic [15:0] num;
    logic [3:0]  grant, pend;
    logic        busy;

    digit_inc_arbiter dut (
        .clk(clk), .rst(rst), .sw(sw), .dir(dir),
        .num(num), .grant(grant), .busy(busy), .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { int edge_n; int idx; } exp_t;
    exp_t q[$];

    // Reference model state
    int          cyc = 0;
    logic [3:0]  h0, h1, h2, m_pend, setm, wr_val, op;
    logic [15:0] m_vis;
    int          m_ptr, next_ok, wr_edge, wr_idx, clr_edge, clr_idx, lg, g_idx;
    bit          wr_v, clr_v, gnt, m_busy;

    task automatic model_reset();
        h0 = '0; h1 = '0; h2 = '0; m_pend = '0; m_ptr = 0;
        m_vis = 16'h0010; next_ok = 0; wr_v = 0; clr_v = 0; lg = -10; m_busy = 0;
        q.delete();
    endtask

    // A switch sampled 1 at edge e after 0 at e-1 becomes pending at edge e+2.
    // A grant at g writes the digit at g+1 and clears its request at g+1;
    // the next grant can come no earlier than g+2.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                model_reset();
            end else begin
                setm = h1 & ~h2;
                h2 = h1; h1 = h0; h0 = sw;
                if (wr_v && wr_edge == cyc) begin
                    m_vis[wr_idx*4 +: 4] = wr_val;
                    wr_v = 0;
                end
                gnt = 0;
                if (cyc >= next_ok && m_pend != 0) begin
                    for (int k = 0; k < 4; k++)
                        if (!gnt && m_pend[(m_ptr + k) % 4]) begin
                            gnt = 1;
                            g_idx = (m_ptr + k) % 4;
                        end
                    op = m_vis[g_idx*4 +: 4];
                    wr_val = 4'((int'(op) + (dir ? 15 : 1)) % 16);
                    wr_v = 1; wr_edge = cyc + 1; wr_idx = g_idx;
                    clr_v = 1; clr_edge = cyc + 1; clr_idx = g_idx;
                    m_ptr = (g_idx + 1) % 4;
                    next_ok = cyc + 2;
                    q.push_back('{cyc, g_idx});
                end
                m_busy = gnt || (lg == cyc - 1);
                if (gnt) lg = cyc;
                if (clr_v && clr_edge == cyc) begin
                    m_pend[clr_idx] = 1'b0;
                    clr_v = 0;
                end
                m_pend = m_pend | setm;
            end
        end
    end

    // Monitor
    initial begin
        logic [3:0] eg;
        forever begin
            @(posedge clk);
            #1;
            check("num", num, m_vis);
            check("pend", {12'h0, pend}, {12'h0, m_pend});
            check("busy", {15'h0, busy}, {15'h0, m_busy});
            eg = 4'b0000;
            if (q.size() > 0 && q[0].edge_n == cyc) begin
                eg = 4'b0001 << q[0].idx;
                void'(q.pop_front());
            end
            check("grant", {12'h0, grant}, {12'h0, eg});
        end
    end

    task automatic tick(input logic [3:0] s, input logic d, input logic r);
        @(negedge clk);
        sw = s; dir = d; rst = r;
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) tick(4'b0000, d, 1'b0);
    endtask

    task automatic do_reset();
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic [3:0] s, input logic d);
        tick(s, d, 1'b0); tick(s, d, 1'b0);
        tick(4'b0000, d, 1'b0); tick(4'b0000, d, 1'b0);
    endtask

    initial begin
        logic [3:0] rs;
        rst = 1'b1; sw = '0; dir = 1'b0;
        do_reset();
        @(negedge clk);
        check("reset_num", num, 16'h0010);
        check("reset_pend", {12'h0, pend}, 16'h0);

        // single increment with a held switch
        for (int i = 0; i < 10; i++) tick(4'b0001, 1'b0, 1'b0);
        idle(6, 1'b0);
        check("single_inc", num, 16'h0011);

        // wrap up and down on digit 1
        do_reset();
        for (int i = 0; i < 14; i++) pulse(4'b0010, 1'b0);
        idle(6, 1'b0);
        check("preload_F", num, 16'h00F0);
        pulse(4'b0010, 1'b0);
        idle(6, 1'b0);
        check("wrap_up", num, 16'h0000);
        pulse(4'b0010, 1'b1);
        idle(6, 1'b1);
        check("wrap_down", num, 16'h00F0);

        // all four switches at once, straight out of reset
        tick(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) tick(4'b1111, 1'b0, 1'b0);
        idle(6, 1'b0);
        check("simultaneous", num, 16'h1121);

        // fairness: digit 0 toggling, digit 2 pulsed once
        do_reset();
        for (int i = 0; i < 24; i++)
            tick({1'b0, (i == 5 || i == 6), 1'b0, ((i % 4) < 2)}, 1'b0, 1'b0);
        idle(8, 1'b0);
        check("fair_digit2", {12'h0, num[11:8]}, 16'h0001);

        // merge: second rise on digit 3 while it waits behind digit 0
        do_reset();
        tick(4'b1001, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0);
        tick(4'b1000, 1'b0, 1'b0);
        idle(10, 1'b0);
        check("merge", num, 16'h1011);

        // coincide: second rise lands on the clear edge
        do_reset();
        tick(4'b1000, 1'b0, 1'b0); tick(4'b0000, 1'b0, 1'b0);
        tick(4'b1000, 1'b0, 1'b0);
        idle(10, 1'b0);
        check("coincide", {12'h0, num[15:12]}, 16'h0002);

        // reset during OPER aborts the write
        do_reset();
        tick(4'b0100, 1'b0, 1'b0);
        idle(3, 1'b0);
        @(negedge clk);
        check("oper_grant", {12'h0, grant}, 16'h0004);
        rst = 1'b1;
        @(negedge clk);
        check("abort_num", num, 16'h0010);
        check("abort_pend", {12'h0, pend}, 16'h0);
        rst = 1'b0;
        idle(6, 1'b0);
        check("abort_nowrite", num, 16'h0010);

        // random traffic
        rs = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) rs[b] = ~rs[b];
            tick(rs, 1'($urandom), ($urandom_range(0, 149) == 0));
        end
        idle(15, 1'b0);
        check("drain", 16'(q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
